sprite_table: RTL and testbench
===============================

# sprite_table

Double-buffered sprite attribute table between the Avalon bus and the sprite controller. Software writes sprite words (id in bits [24:20], position/attributes in [19:0]) into a pending bank at any time, then arms a commit. At the next vertical-blank start, the block copies the pending bank into the active bank one entry per cycle, so the display never shows a half-updated frame. The sprite controller reads the active bank through a registered lookup port.

## Interface
- NUM_SPRITES, 20: table entries, legal range 1..30.
- VBLANK_LINE, 480: VGA_VCOUNT value that marks vblank start.

- clk  in  1  system clock. VGA_HCOUNT/VGA_VCOUNT are synchronous to it.
- reset  in  1  synchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe. Qualified by chipselect.
- read  in  1  Avalon read strobe. Qualified by chipselect.
- address  in  5  Avalon word address.
- gl_input  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- VGA_VCOUNT  in  10  current display line.
- rd_index  in  5  sprite controller lookup index.
- rd_sprite  out  25  active entry at rd_index, registered.
- commit_busy  out  1  high while in ARMED or COPY.
- frame_count  out  16  number of completed commits, wraps.

## Operation
- Address map:
  - 0..NUM_SPRITES-1: pending entry. On write, stores gl_input[24:0] and ignores bits [31:25]. On read, returns the entry zero-extended to 32 bits.
  - 30 (write): bit0=1 requests a commit. Other bits are ignored.
  - 31 (read): status word {frame_count[15:0], 13'b0, rearm, state==COPY, state==ARMED}.
  - Any other address: writes are ignored, reads return 0.
- Vblank edge: vcount_q is VGA_VCOUNT registered. The edge fires in a cycle where VGA_VCOUNT==VBLANK_LINE and vcount_q!=VBLANK_LINE.
- FSM:
  - IDLE -> ARMED on a commit request.
  - ARMED -> COPY on a vblank edge, with idx=0.
  - COPY: each cycle, active[idx] <= pending[idx] and idx++.
  - When idx==NUM_SPRITES-1, the copy completes. frame_count++. Next state is ARMED if rearm is set (rearm clears), otherwise IDLE.
- Commit request while ARMED: no effect.
- Commit request while COPY: sets rearm.
- Commit request in the same cycle as a vblank edge while IDLE: goes to ARMED and does not use that edge. The copy waits for the next frame.
- Pending writes are accepted in every state.
  - The copy reads pending before that cycle's write.
  - A write to index k in the same cycle that k is copied leaves the old value in active and the new value in pending.
  - A write to an index not yet copied is picked up by the ongoing copy.
- rd_sprite = active[rd_index]. An index >= NUM_SPRITES returns 0. A same-cycle copy into that index returns the pre-copy value.
- Reset (including mid-COPY): both banks cleared to 0; FSM IDLE; idx, rearm, frame_count, readdata, rd_sprite all 0; commit_busy 0; vcount_q 0.

## Timing
- Pending write at cycle T is visible on a read issued at T+1 or later.
- readdata is valid the cycle after the read strobe. It holds its value otherwise.
- Read and write to the same pending address in the same cycle: readdata returns the old value.
- Vblank edge detected at cycle E (FSM in ARMED):
  - COPY runs E+1..E+NUM_SPRITES.
  - active[i] is written at E+1+i and visible on rd_sprite from E+2+i when rd_index=i is held.
  - FSM leaves COPY and frame_count increments at E+NUM_SPRITES+1.
- Commit-request-to-ARMED: 1 cycle. commit_busy rises the cycle after the control write.
- frame_count wraps 0xFFFF -> 0x0000.

## Test plan
- Reset, then write pending[0]=0x01_0A0B0, and read addresses 0 and 31 -> readdata 0x010A0B0, then 0. rd_sprite with rd_index=0 stays 0 (no commit).
- Write pending[0]=0x1_00000 and pending[19]=0x3_00000, commit, sweep VGA_VCOUNT 479->480 -> active[0] is visible at E+2, active[19] at E+21. frame_count=1 and commit_busy=0 at E+21.
- During COPY at E+5 (idx 4), write pending[4]=0xAAAAAA and pending[10]=0x555555 -> active[4] keeps its old value, active[10]=0x555555, pending[4]=0xAAAAAA.
- Commit while COPY -> rearm=1, FSM goes to ARMED after the copy, and a second copy runs on the next vblank edge. frame_count advances by 2 in total.
- Commit in the same cycle as the vblank edge while IDLE -> no copy this frame; copy on the next edge.
- Assert reset at E+10 -> both banks are 0, FSM is IDLE, and frame_count is 0. rd_sprite reads 0 for indices 0..31.

Source files
------------

// File: rtl/sprite_table.sv
// Double-buffered sprite attribute table: the bus writes a pending bank, and an armed
// commit copies it into the active bank one entry per cycle starting at vblank.
module sprite_table #(
   parameter int NUM_SPRITES = 20,
   parameter int VBLANK_LINE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [4:0]  address,
   input  logic [31:0] gl_input,
   output logic [31:0] readdata,
   input  logic [9:0]  VGA_VCOUNT,
   input  logic [4:0]  rd_index,
   output logic [24:0] rd_sprite,
   output logic        commit_busy,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

   localparam logic [4:0] NUM_S    = 5'(NUM_SPRITES);
   localparam logic [4:0] LAST_IDX = 5'(NUM_SPRITES - 1);
   localparam logic [9:0] VB_LINE  = 10'(VBLANK_LINE);
   localparam logic [4:0] CTRL_ADR = 5'd30;
   localparam logic [4:0] STAT_ADR = 5'd31;

   logic [24:0] pending_q [NUM_SPRITES];
   logic [24:0] active_q  [NUM_SPRITES];

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        rearm_q, rearm_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [31:0] readdata_q, readdata_d;
   logic [24:0] rd_sprite_q, rd_sprite_d;
   logic [9:0]  vcount_q;

   logic        wr_en, rd_en, pend_hit, commit_req, vblank_edge, copy_en;
   logic [31:0] status;
   logic        unused_bits;

   assign unused_bits = ^gl_input[31:25];

   assign wr_en       = chipselect && write;
   assign rd_en       = chipselect && read;
   assign pend_hit    = (address < NUM_S);
   assign commit_req  = wr_en && (address == CTRL_ADR) && gl_input[0];
   assign vblank_edge = (VGA_VCOUNT == VB_LINE) && (vcount_q != VB_LINE);
   assign status      = {frame_count_q, 13'b0, rearm_q, state_q == COPY, state_q == ARMED};

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rearm_d       = rearm_q;
      frame_count_d = frame_count_q;
      copy_en       = 1'b0;
      case (state_q)
         IDLE: begin
            // A vblank edge coinciding with the request is deliberately not used.
            if (commit_req) state_d = ARMED;
         end
         ARMED: begin
            if (vblank_edge) begin
               state_d = COPY;
               idx_d   = 5'd0;
            end
         end
         COPY: begin
            copy_en = 1'b1;
            if (idx_q == LAST_IDX) begin
               frame_count_d = frame_count_q + 16'd1;
               rearm_d       = 1'b0;
               idx_d         = 5'd0;
               state_d       = (rearm_q || commit_req) ? ARMED : IDLE;
            end else begin
               idx_d = idx_q + 5'd1;
               if (commit_req) rearm_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         if (pend_hit)                 readdata_d = {7'b0, pending_q[address]};
         else if (address == STAT_ADR) readdata_d = status;
         else                          readdata_d = 32'd0;
      end
      rd_sprite_d = (rd_index < NUM_S) ? active_q[rd_index] : 25'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= 5'd0;
         rearm_q       <= 1'b0;
         frame_count_q <= 16'd0;
         readdata_q    <= 32'd0;
         rd_sprite_q   <= 25'd0;
         vcount_q      <= 10'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rearm_q       <= rearm_d;
         frame_count_q <= frame_count_d;
         readdata_q    <= readdata_d;
         rd_sprite_q   <= rd_sprite_d;
         vcount_q      <= VGA_VCOUNT;
      end
   end

   // Non-blocking update means the copy sees pending as it was before this cycle's write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pending_q[i] <= 25'd0;
            active_q[i]  <= 25'd0;
         end
      end else begin
         if (wr_en && pend_hit) pending_q[address] <= gl_input[24:0];
         if (copy_en)           active_q[idx_q]    <= pending_q[idx_q];
      end
   end

   assign readdata    = readdata_q;
   assign rd_sprite   = rd_sprite_q;
   assign commit_busy = (state_q != IDLE);
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sprite_table.sv
// Scoreboard bench for sprite_table: stimulus queues expectations, a negedge monitor checks them.
module tb_sprite_table;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [4:0]  address = 5'd0;
   logic [31:0] gl_input = 32'd0;
   logic [31:0] readdata;
   logic [9:0]  VGA_VCOUNT = 10'd0;
   logic [4:0]  rd_index = 5'd0;
   logic [24:0] rd_sprite;
   logic        commit_busy;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   sprite_table dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .gl_input(gl_input), .readdata(readdata),
      .VGA_VCOUNT(VGA_VCOUNT), .rd_index(rd_index), .rd_sprite(rd_sprite),
      .commit_busy(commit_busy), .frame_count(frame_count)
   );

   localparam int K_RD = 0, K_SPR = 1, K_FC = 2, K_BUSY = 3;

   typedef struct {
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t        pq[$];
   logic [31:0] rdq[$];
   logic        rd_seen = 1'b0;
   logic        drain_chk = 1'b0;
   int          checks = 0;
   int          failures = 0;

   function automatic string kname(input int k);
      case (k)
         K_RD:    return "readdata";
         K_SPR:   return "rd_sprite";
         K_FC:    return "frame_count";
         default: return "commit_busy";
      endcase
   endfunction

   always @(posedge clk) rd_seen <= chipselect && read;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      logic [31:0] x;
      if (rd_seen) begin
         checks++;
         if (rdq.size() == 0) begin
            failures++;
            $display("FAIL readdata_unexpected: got %h, no expectation queued", readdata);
         end else begin
            x = rdq.pop_front();
            if (readdata !== x) begin
               failures++;
               $display("FAIL bus_read: got %h expected %h at %0t", readdata, x, $time);
            end
         end
      end
      while (pq.size() > 0) begin
         e = pq.pop_front();
         case (e.kind)
            K_RD:    act = readdata;
            K_SPR:   act = {7'b0, rd_sprite};
            K_FC:    act = {16'b0, frame_count};
            default: act = {31'b0, commit_busy};
         endcase
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", kname(e.kind), act, e.val, $time);
         end
      end
      if (drain_chk) begin
         checks++;
         if (rdq.size() != 0 || pq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d reads and %0d probes left unchecked", rdq.size(), pq.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; gl_input = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp_v);
      chipselect = 1'b1; read = 1'b1; address = a;
      rdq.push_back(exp_v);
      tick();
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic probe(input int k, input logic [31:0] v);
      exp_t e;
      e.kind = k;
      e.val  = v;
      pq.push_back(e);
   endtask

   // Ends on the clock edge where the DUT sees the vblank edge (E).
   task automatic vblank_sweep();
      VGA_VCOUNT = 10'd0;   tick();
      VGA_VCOUNT = 10'd479; tick();
      VGA_VCOUNT = 10'd480; tick();
   endtask

   initial begin
      // Reset state
      ticks(3);
      probe(K_RD, 32'd0); probe(K_SPR, 32'd0); probe(K_FC, 32'd0); probe(K_BUSY, 32'd0);
      reset = 1'b0;
      tick();

      // Pending writes/reads, no commit
      wr(5'd0, 32'hFE10A0B0);
      rd(5'd0, 32'h010A0B0);
      rd(5'd31, 32'd0);
      rd(5'd5, 32'd0);
      wr(5'd25, 32'h123);
      rd(5'd25, 32'd0);
      rd(5'd30, 32'd0);
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 5'd1; gl_input = 32'h0000BEEF;
      rdq.push_back(32'd0);
      tick();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      rd(5'd1, 32'h0000BEEF);
      ticks(2);
      probe(K_RD, 32'h0000BEEF);
      rd_index = 5'd0;
      tick();
      probe(K_SPR, 32'd0);

      // First commit, mid-copy writes
      wr(5'd0, 32'h00100000);
      wr(5'd19, 32'h00300000);
      wr(5'd4, 32'h00000044);
      wr(5'd30, 32'hFFFFFFFE);
      probe(K_BUSY, 32'd0);
      wr(5'd30, 32'h1);
      probe(K_BUSY, 32'd1);
      rd(5'd31, 32'h00000001);
      wr(5'd30, 32'h1);
      rd(5'd31, 32'h00000001);
      VGA_VCOUNT = 10'd479; tick();
      VGA_VCOUNT = 10'd480; tick();
      rd_index = 5'd0;
      tick(); probe(K_SPR, 32'd0);
      tick(); probe(K_SPR, 32'h00100000);
      ticks(2);
      wr(5'd4, 32'h00AAAAAA);
      wr(5'd10, 32'h00555555);
      rd_index = 5'd4;
      tick(); probe(K_SPR, 32'h00000044);
      rd_index = 5'd19;
      ticks(13); probe(K_SPR, 32'd0);
      tick();
      probe(K_SPR, 32'h00300000); probe(K_FC, 32'd1); probe(K_BUSY, 32'd0);
      rd_index = 5'd10;
      tick(); probe(K_SPR, 32'h00555555);
      rd(5'd4, 32'h00AAAAAA);
      rd(5'd10, 32'h00555555);
      rd_index = 5'd4;
      tick(); probe(K_SPR, 32'h00000044);
      rd_index = 5'd20;
      tick(); probe(K_SPR, 32'd0);

      // Commit during COPY re-arms for the next frame
      rd_index = 5'd0;
      VGA_VCOUNT = 10'd0; tick();
      wr(5'd30, 32'h1);
      VGA_VCOUNT = 10'd479; tick();
      VGA_VCOUNT = 10'd480; tick();
      ticks(3);
      wr(5'd30, 32'h1);
      rd(5'd31, 32'h00010006);
      ticks(16);
      rd(5'd31, 32'h00020001);
      ticks(3);
      probe(K_FC, 32'd2); probe(K_BUSY, 32'd1);
      wr(5'd0, 32'h01234567);
      vblank_sweep();
      ticks(21);
      probe(K_FC, 32'd3); probe(K_BUSY, 32'd0); probe(K_SPR, 32'h01234567);

      // Commit on the same edge as vblank while IDLE waits a frame
      wr(5'd0, 32'h00000077);
      VGA_VCOUNT = 10'd0;   tick();
      VGA_VCOUNT = 10'd479; tick();
      VGA_VCOUNT = 10'd480;
      wr(5'd30, 32'h1);
      probe(K_BUSY, 32'd1);
      ticks(25);
      probe(K_FC, 32'd3); probe(K_SPR, 32'h01234567); probe(K_BUSY, 32'd1);
      vblank_sweep();
      ticks(21);
      probe(K_FC, 32'd4); probe(K_BUSY, 32'd0); probe(K_SPR, 32'h00000077);

      // Reset in the middle of a copy
      wr(5'd5, 32'h00000055);
      wr(5'd30, 32'h1);
      vblank_sweep();
      ticks(9);
      reset = 1'b1;
      tick();
      probe(K_FC, 32'd0); probe(K_BUSY, 32'd0); probe(K_RD, 32'd0); probe(K_SPR, 32'd0);
      reset = 1'b0;
      rd(5'd0, 32'd0);
      rd(5'd5, 32'd0);
      rd(5'd31, 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd_index = 5'(i);
         tick();
         probe(K_SPR, 32'd0);
      end

      tick();
      drain_chk = 1'b1;
      tick();
      drain_chk = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
